ex_md_unit: RTL
===============

EX_MD_UNIT -- requirements
Module: ex_md_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/HI/LO width; legal values 8..64, even.
REQ-002 SHALL have parameter CNT_W, default $clog2(DATA_W)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port funct  input  6  ID-stage funct code of instruction in EX.
REQ-006 SHALL have port op_valid  input  1  funct/operands valid this cycle.
REQ-007 SHALL have port operand_1  input  DATA_W  rs value (dividend / multiplicand / MTHI-MTLO source).
REQ-008 SHALL have port operand_2  input  DATA_W  rt value (divisor / multiplier).
REQ-009 SHALL have port flush  input  1  kill in-flight operation.
REQ-010 SHALL have port stall_req  output  1  hold IF/ID/EX; EX instruction not complete.
REQ-011 SHALL have port result  output  DATA_W  MFHI/MFLO read data to WB path, else 0.
REQ-012 SHALL have port done  output  1  one-cycle pulse, HI/LO just updated by MULT*/DIV*.
REQ-013 SHALL have ports hi_out, lo_out  output  DATA_W  current HI, LO registers.

Function
REQ-014 SHALL decode MULT 6'h18, MULTU 6'h19, DIV 6'h1a, DIVU 6'h1b, MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13; other functs ignored (no state change, result 0).
REQ-015 SHALL use states IDLE, RUN, DONE; reset and flush force IDLE.
REQ-016 IDLE: op_valid with MULT*/DIV* SHALL latch operands, op type and signedness, clear counter, go RUN; stall_req high in that cycle.
REQ-017 RUN: SHALL perform one radix-2 step per cycle for exactly DATA_W cycles, stall_req high; on the last RUN edge HI/LO SHALL be written and state SHALL go DONE.
REQ-018 DONE: stall_req low, done high, op_valid ignored, next state IDLE unconditionally (prevents re-issue of the stalled instruction).
REQ-019 Latency: MULT*/DIV* SHALL stall exactly DATA_W+1 cycles (33 at default), instruction retires in the DONE cycle.
REQ-020 MULT/MULTU: {HI,LO} SHALL equal the 2*DATA_W signed/unsigned product.
REQ-021 DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with sign of dividend; signed ops on magnitudes with sign fix-up.
REQ-022 Divide by zero: LO SHALL be all ones, HI SHALL be dividend, same latency.
REQ-023 Signed most-negative / -1: LO SHALL be most-negative value, HI SHALL be 0.
REQ-024 MTHI/MTLO in IDLE SHALL write operand_1 to HI/LO at the edge, no stall.
REQ-025 MFHI/MFLO in IDLE SHALL drive result combinationally from HI/LO, no stall.
REQ-026 Any HI/LO instruction with op_valid while state is RUN SHALL keep stall_req high and take no action until IDLE.
REQ-027 flush in any state SHALL return to IDLE next edge, HI/LO unchanged, no done pulse; flush overrides a same-cycle start.
REQ-028 Outputs SHALL not depend on operand values while state is RUN (operands latched).

Reset
REQ-029 rst SHALL, at the next edge, set state IDLE, counter 0, HI 0, LO 0, internal operand/accumulator registers 0.
REQ-030 During and after reset: stall_req 0, done 0, result 0, hi_out 0, lo_out 0.
REQ-031 rst asserted mid-RUN SHALL abandon the operation with no HI/LO write; rst has priority over flush and start.

Structure
REQ-032 Funct codes of REQ-014 SHALL be added to the shared funct header; IDLE/RUN/DONE encoding SHALL live in a shared header as constants.
REQ-033 Radix-2 shift-add multiply / shift-subtract divide datapath SHALL be one sub-module, md_iter_core, parametrised by DATA_W; FSM, HI/LO and decode stay in ex_md_unit.

Verification
REQ-034 MULT 0xFFFFFFFE x 0x00000003 -> stall_req 33 cycles, done pulse, HI 0xFFFFFFFF, LO 0xFFFFFFFA; MULTU same operands -> HI 0x00000002, LO 0xFFFFFFFA.
REQ-035 DIV -7 / 2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF; DIVU 7 / 0 -> LO 0xFFFFFFFF, HI 0x00000007; DIV 0x80000000 / 0xFFFFFFFF -> LO 0x80000000, HI 0.
REQ-036 MTHI 0x12345678 then MFHI -> result 0x12345678, no stall; MFLO issued during RUN -> stalled until DONE, then returns new LO.
REQ-037 flush at RUN cycle 10 of DIVU 100/7 -> IDLE next cycle, no done, HI/LO keep prior values; rst at RUN cycle 5 -> HI/LO 0, stall_req 0.
REQ-038 DATA_W=16: MULTU 0xFFFF x 0xFFFF -> 17 stall cycles, HI 0xFFFE, LO 0x0001; random signed/unsigned mult/div vs reference model, 10k ops, zero mismatches.

Source files
------------

// File: rtl/ex_md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct codes,
// FSM state encoding and small decode helpers.
package ex_md_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_RUN  = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = MD_IDLE,
        ST_RUN  = MD_RUN,
        ST_DONE = MD_DONE
    } md_state_e;

    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [5:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/ex_md_unit_md_iter_core.sv
// Radix-2 iterative datapath: shift-add multiply and restoring shift-subtract
// divide on operand magnitudes, with sign fix-up applied on the way out.
module md_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic              is_signed_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int W = DATA_W;

    // acc holds {product-high, multiplier} for MULT and {remainder, quotient} for DIV
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   a_raw_q, a_raw_d;
    logic           is_div_q, is_div_d;
    logic           neg_lo_q, neg_lo_d;
    logic           neg_hi_q, neg_hi_d;
    logic           div0_q, div0_d;

    logic           a_neg, b_neg;
    logic [W:0]     add_sum;
    logic [W:0]     r_shift;
    logic [W:0]     r_diff;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    assign a_neg   = is_signed_i & op_a_i[W-1];
    assign b_neg   = is_signed_i & op_b_i[W-1];
    assign add_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign r_shift = acc_q[2*W-1:W-1];
    assign r_diff  = r_shift - {1'b0, opb_q};

    always_comb begin
        acc_d    = acc_q;
        opb_d    = opb_q;
        a_raw_d  = a_raw_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        if (load_i) begin
            acc_d    = {{W{1'b0}}, mag(op_a_i, a_neg)};
            opb_d    = mag(op_b_i, b_neg);
            a_raw_d  = op_a_i;
            is_div_d = is_div_i;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = is_div_i ? a_neg : (a_neg ^ b_neg);
            div0_d   = is_div_i && (op_b_i == '0);
        end else if (step_i) begin
            if (is_div_q) begin
                if (!r_diff[W]) begin
                    acc_d = {r_diff[W-1:0], acc_q[W-2:0], 1'b1};
                end else begin
                    acc_d = {r_shift[W-1:0], acc_q[W-2:0], 1'b0};
                end
            end else begin
                acc_d = {add_sum, acc_q[W-1:1]};
            end
        end
    end

    // Results track acc_d so the owner can capture them on the final step edge
    always_comb begin
        prod = neg_lo_q ? -acc_d : acc_d;
        quo  = neg_lo_q ? -acc_d[W-1:0] : acc_d[W-1:0];
        rem  = neg_hi_q ? -acc_d[2*W-1:W] : acc_d[2*W-1:W];
        if (!is_div_q) begin
            hi_o = prod[2*W-1:W];
            lo_o = prod[W-1:0];
        end else if (div0_q) begin
            hi_o = a_raw_q;
            lo_o = '1;
        end else begin
            hi_o = rem;
            lo_o = quo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            opb_q    <= '0;
            a_raw_q  <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            a_raw_q  <= a_raw_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
        end
    end

endmodule

// File: rtl/ex_md_unit.sv
// EX-stage HI/LO unit: decodes MULT*/DIV*/MFHI/MFLO/MTHI/MTLO, owns HI/LO and
// sequences the iterative core through IDLE -> RUN -> DONE, stalling the pipe.
module ex_md_unit
    import ex_md_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        funct,
    input  logic              op_valid,
    input  logic [DATA_W-1:0] operand_1,
    input  logic [DATA_W-1:0] operand_2,
    input  logic              flush,
    output logic              stall_req,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output md_state_e         state_o
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic              stall_c, done_c;
    logic [DATA_W-1:0] result_c;
    logic              core_load, core_step;
    logic [DATA_W-1:0] core_hi, core_lo;

    md_iter_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .load_i      (core_load),
        .step_i      (core_step),
        .is_div_i    (md_is_div(funct)),
        .is_signed_i (md_is_signed(funct)),
        .op_a_i      (operand_1),
        .op_b_i      (operand_2),
        .hi_o        (core_hi),
        .lo_o        (core_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        result_c  = '0;
        core_load = 1'b0;
        core_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    if (is_md_funct(funct)) begin
                        core_load = 1'b1;
                        stall_c   = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_RUN;
                    end else begin
                        case (funct)
                            FUNCT_MTHI: hi_d = operand_1;
                            FUNCT_MTLO: lo_d = operand_1;
                            FUNCT_MFHI: result_c = hi_q;
                            FUNCT_MFLO: result_c = lo_q;
                            default:    ;
                        endcase
                    end
                end
            end
            ST_RUN: begin
                stall_c   = 1'b1;
                core_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    hi_d    = core_hi;
                    lo_d    = core_lo;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // The stalled instruction retires here; it must not restart
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            hi_d      = hi_q;
            lo_d      = lo_q;
            stall_c   = 1'b0;
            done_c    = 1'b0;
            result_c  = '0;
            core_load = 1'b0;
            core_step = 1'b0;
        end

        if (rst) begin
            stall_c  = 1'b0;
            done_c   = 1'b0;
            result_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign stall_req = stall_c;
    assign done      = done_c;
    assign result    = result_c;
    assign hi_out    = rst ? '0 : hi_q;
    assign lo_out    = rst ? '0 : lo_q;
    assign state_o   = state_q;

endmodule
